// File: rtl/laneswitch_pkg.sv
// Shared encodings and defaults for the lane-switch ownership sequencer.
// Lane indices double as the datapath switch polarity (0 routes memory to lane0).
package laneswitch_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GRANT0 = 3'd3,
    ST_GRANT1 = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  localparam int DEF_DRAIN_CYCLES  = 2;
  localparam int DEF_SETTLE_CYCLES = 3;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic state_t grant_state(input logic lane);
    return (lane == LANE1) ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/laneswitch_ctrl_if.sv
// Lane handshake plus datapath status bundle between the lanes/datapath and the
// ownership controller.
interface laneswitch_ctrl_if #(
  parameter int FCNT_WIDTH = 8
);
  logic                  lane0_req;
  logic                  lane1_req;
  logic                  lane0_done;
  logic                  lane1_done;
  logic                  lane0_grant;
  logic                  lane1_grant;
  logic                  switch;
  logic                  active;
  logic                  fault;
  logic                  busy;
  logic [FCNT_WIDTH-1:0] fault_count;
  logic                  proto_err;

  modport master (
    output lane0_req, lane1_req, lane0_done, lane1_done, active, fault,
    input  lane0_grant, lane1_grant, switch, busy, fault_count, proto_err
  );

  modport slave (
    input  lane0_req, lane1_req, lane0_done, lane1_done, active, fault,
    output lane0_grant, lane1_grant, switch, busy, fault_count, proto_err
  );
endinterface

// File: rtl/laneswitch_rr_arb2.sv
// Two-requester round-robin picker; on contention the lane that did not own the
// memory last wins. Purely combinational.
module laneswitch_rr_arb2
  import laneswitch_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_target,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_target = LANE0;
    if (i_req == 2'b11) begin
      o_target = ~i_last_owner;
    end else if (i_req[1]) begin
      o_target = LANE1;
    end
  end

endmodule

// File: rtl/laneswitch_ctrl.sv
// Ownership sequencer for a shared 2-port buffer: grants one lane at a time, drains
// memory traffic before hand-over and toggles switch only from IDLE.
module laneswitch_ctrl
  import laneswitch_pkg::*;
#(
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FCNT_WIDTH    = 8
) (
  input logic              clk,
  input logic              reset_n,
  laneswitch_ctrl_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  state_t                r_state, w_state_next;
  logic [SW-1:0]         r_settle_cnt, w_settle_next;
  logic [DW-1:0]         r_drain_cnt, w_drain_next;
  logic                  r_switch, w_switch_next;
  logic                  r_target, w_target_next;
  logic                  r_last_owner, w_last_next;
  logic                  r_grant0, r_grant1, r_busy, r_proto_err;
  logic [FCNT_WIDTH-1:0] r_fault_count;
  logic                  w_perr_set;
  logic [1:0]            w_req;
  logic                  w_arb_target, w_arb_valid;

  assign w_req = {bus.lane1_req, bus.lane0_req};

  laneswitch_rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_owner (r_last_owner),
    .o_target     (w_arb_target),
    .o_valid      (w_arb_valid)
  );

  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle_cnt;
    w_drain_next  = r_drain_cnt;
    w_switch_next = r_switch;
    w_target_next = r_target;
    w_last_next   = r_last_owner;
    w_perr_set    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_settle_cnt <= SW'(1)) w_state_next = ST_IDLE;
        else                        w_settle_next = r_settle_cnt - SW'(1);
      end
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_target_next = w_arb_target;
          if (w_arb_target == r_switch) begin
            w_state_next = grant_state(w_arb_target);
          end else begin
            w_switch_next = ~r_switch;
            w_settle_next = SW'(SETTLE_CYCLES);
            w_state_next  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        // A request dropped here still receives its grant once settled.
        if (r_settle_cnt <= SW'(1)) w_state_next = grant_state(r_target);
        else                        w_settle_next = r_settle_cnt - SW'(1);
      end
      ST_GRANT0: begin
        if (bus.lane0_done) begin
          w_last_next  = LANE0;
          w_drain_next = '0;
          w_state_next = ST_DRAIN;
        end
        if (bus.lane1_done) w_perr_set = 1'b1;
      end
      ST_GRANT1: begin
        if (bus.lane1_done) begin
          w_last_next  = LANE1;
          w_drain_next = '0;
          w_state_next = ST_DRAIN;
        end
        if (bus.lane0_done) w_perr_set = 1'b1;
      end
      ST_DRAIN: begin
        if (bus.active)                                  w_drain_next = '0;
        else if ((r_drain_cnt + DW'(1)) >= DW'(DRAIN_CYCLES)) w_state_next = ST_IDLE;
        else                                             w_drain_next = r_drain_cnt + DW'(1);
      end
      default: w_state_next = ST_INIT;
    endcase
    if ((r_state != ST_GRANT0) && (r_state != ST_GRANT1) &&
        (bus.lane0_done || bus.lane1_done)) begin
      w_perr_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_settle_cnt  <= SW'(SETTLE_CYCLES);
      r_drain_cnt   <= '0;
      r_switch      <= LANE0;
      r_target      <= LANE0;
      r_last_owner  <= LANE1;
      r_grant0      <= 1'b0;
      r_grant1      <= 1'b0;
      r_busy        <= 1'b1;
      r_fault_count <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_next;
      r_drain_cnt  <= w_drain_next;
      r_switch     <= w_switch_next;
      r_target     <= w_target_next;
      r_last_owner <= w_last_next;
      // Outputs are registered from the next state so grants align with state.
      r_grant0     <= (w_state_next == ST_GRANT0);
      r_grant1     <= (w_state_next == ST_GRANT1);
      r_busy       <= (w_state_next != ST_IDLE);
      if (bus.fault && (r_fault_count != '1)) r_fault_count <= r_fault_count + FCNT_WIDTH'(1);
      if (w_perr_set) r_proto_err <= 1'b1;
    end
  end

  assign bus.lane0_grant = r_grant0;
  assign bus.lane1_grant = r_grant1;
  assign bus.switch      = r_switch;
  assign bus.busy        = r_busy;
  assign bus.fault_count = r_fault_count;
  assign bus.proto_err   = r_proto_err;

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// Directed bench for laneswitch_ctrl: reset, grants, hand-over, fairness, protocol
// errors, fault saturation and mid-operation reset. Inputs change and outputs are sampled on negedge.
module tb_laneswitch_ctrl;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  laneswitch_ctrl_if #(.FCNT_WIDTH(8)) bus ();

  laneswitch_ctrl #(
    .DRAIN_CYCLES  (2),
    .SETTLE_CYCLES (3),
    .FCNT_WIDTH    (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // {lane0_grant, lane1_grant, switch, busy}
  function automatic logic [3:0] obs4();
    return {bus.lane0_grant, bus.lane1_grant, bus.switch, bus.busy};
  endfunction

  task automatic test_reset();
    logic [3:0] o;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b0001) begin bad++; $display("FAIL reset_outs: got=%b want=%b", o, 4'b0001); end
    total++;
    if ({bus.fault_count, bus.proto_err} !== 9'd0) begin
      bad++; $display("FAIL reset_cnt_err: got=%h want=0", {bus.fault_count, bus.proto_err});
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      o = obs4(); total++;
      if (o !== ((i == 3) ? 4'b0000 : 4'b0001)) begin
        bad++; $display("FAIL reset_init_%0d: got=%b want=%b", i, o, (i == 3) ? 4'b0000 : 4'b0001);
      end
    end
    $display("reset: idle after 3 cycles checked");
  endtask

  task automatic test_same_lane();
    logic [3:0] o;
    bus.lane0_req = 1'b1;
    @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b1001) begin bad++; $display("FAIL same_grant: got=%b want=%b", o, 4'b1001); end
    bus.lane0_req = 1'b0;
    repeat (4) @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b1001) begin bad++; $display("FAIL same_hold: got=%b want=%b", o, 4'b1001); end
    bus.lane0_done = 1'b1;
    @(negedge clk);
    bus.lane0_done = 1'b0;
    o = obs4(); total++;
    if (o !== 4'b0001) begin bad++; $display("FAIL same_release: got=%b want=%b", o, 4'b0001); end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL same_drain: got=%b want=1", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL same_idle: got=%b want=0", bus.busy); end
    $display("same_lane: grant t+1, idle t+8 checked");
  endtask

  task automatic test_cross_lane();
    logic [3:0] o;
    bus.lane1_req = 1'b1;
    @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b0011) begin bad++; $display("FAIL cross_toggle: got=%b want=%b", o, 4'b0011); end
    repeat (2) @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b0011) begin bad++; $display("FAIL cross_settle: got=%b want=%b", o, 4'b0011); end
    @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b0111) begin bad++; $display("FAIL cross_grant: got=%b want=%b", o, 4'b0111); end
    bus.lane1_req = 1'b0;
    bus.active    = 1'b1;
    @(negedge clk);
    bus.lane1_done = 1'b1;
    @(negedge clk);
    bus.lane1_done = 1'b0;
    o = obs4(); total++;
    if (o !== 4'b0011) begin bad++; $display("FAIL cross_release: got=%b want=%b", o, 4'b0011); end
    repeat (4) @(negedge clk);
    bus.active = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL cross_drain_active: got=%b want=1", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL cross_drain_1: got=%b want=1", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL cross_idle: got=%b want=0", bus.busy); end
    $display("cross_lane: toggle t+1, grant t+4, drain restart checked");
  endtask

  task automatic test_fairness();
    int         n;
    logic       exp_lane;
    logic [2:0] o;
    logic [2:0] want;
    bus.lane0_req = 1'b1;
    bus.lane1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_lane = k[0];
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin bus.lane0_done = 1'b0; bus.lane1_done = 1'b0; end
      end while (!(bus.lane0_grant || bus.lane1_grant) && n < 20);
      o    = {bus.lane0_grant, bus.lane1_grant, bus.switch};
      want = exp_lane ? 3'b011 : 3'b100;
      total++;
      if (o !== want) begin bad++; $display("FAIL fair_grant_%0d: got=%b want=%b", k, o, want); end
      total++;
      if (n !== ((k == 0) ? 4 : 7)) begin
        bad++; $display("FAIL fair_latency_%0d: got=%0d want=%0d", k, n, (k == 0) ? 4 : 7);
      end
      $display("fairness: grant %0d to lane%0d after %0d cycles", k, exp_lane, n);
      bus.active = 1'b1;
      repeat (2) @(negedge clk);
      bus.active = 1'b0;
      if (k == 3) begin bus.lane0_req = 1'b0; bus.lane1_req = 1'b0; end
      if (exp_lane) bus.lane1_done = 1'b1;
      else          bus.lane0_done = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.lane0_done = 1'b0;
      bus.lane1_done = 1'b0;
    end while (bus.busy && n < 20);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL fair_idle: got=%b want=0", bus.busy); end
    total++;
    if (bus.fault_count !== 8'd0) begin bad++; $display("FAIL fair_fcnt: got=%0d want=0", bus.fault_count); end
  endtask

  task automatic test_proto_err();
    int n;
    total++;
    if (bus.proto_err !== 1'b0) begin bad++; $display("FAIL perr_clean: got=%b want=0", bus.proto_err); end
    bus.lane0_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.lane0_grant && n < 20);
    bus.lane0_req = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL perr_grant_latency: got=%0d want=4", n); end
    bus.lane1_done = 1'b1;
    @(negedge clk);
    bus.lane1_done = 1'b0;
    total++;
    if ({bus.proto_err, bus.lane0_grant} !== 2'b11) begin
      bad++; $display("FAIL perr_set: got=%b want=11", {bus.proto_err, bus.lane0_grant});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({bus.proto_err, bus.lane0_grant} !== 2'b11) begin
      bad++; $display("FAIL perr_sticky: got=%b want=11", {bus.proto_err, bus.lane0_grant});
    end
    bus.lane0_done = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; bus.lane0_done = 1'b0; end while (bus.busy && n < 20);
    total++;
    if (n !== 3) begin bad++; $display("FAIL perr_release_idle: got=%0d want=3", n); end
    $display("proto_err: non-owner done flagged, owner kept grant");
  endtask

  task automatic test_fault_sat();
    bus.fault = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (bus.fault_count !== 8'd100) begin bad++; $display("FAIL fault_100: got=%0d want=100", bus.fault_count); end
    repeat (200) @(negedge clk);
    bus.fault = 1'b0;
    total++;
    if (bus.fault_count !== 8'd255) begin bad++; $display("FAIL fault_sat: got=%0d want=255", bus.fault_count); end
    @(negedge clk);
    total++;
    if (bus.fault_count !== 8'd255) begin bad++; $display("FAIL fault_hold: got=%0d want=255", bus.fault_count); end
    $display("fault_count: saturation at 255 checked");
  endtask

  task automatic test_reset_mid();
    logic [3:0] o;
    int         n;
    // switch is 0 here, so a lane1 request goes through SETTLE
    bus.lane1_req = 1'b1;
    @(negedge clk);
    o = obs4(); total++;
    if (o !== 4'b0011) begin bad++; $display("FAIL rmid_settle: got=%b want=%b", o, 4'b0011); end
    bus.lane1_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    o = obs4(); total++;
    if (o !== 4'b0001) begin bad++; $display("FAIL rmid_settle_rst: got=%b want=%b", o, 4'b0001); end
    total++;
    if ({bus.fault_count, bus.proto_err} !== 9'd0) begin
      bad++; $display("FAIL rmid_clear: got=%h want=0", {bus.fault_count, bus.proto_err});
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_init_busy: got=%b want=1", bus.busy); end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_init_idle: got=%b want=0", bus.busy); end
    bus.lane1_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.lane1_grant && n < 20);
    bus.lane1_req = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL rmid_grant1_latency: got=%0d want=4", n); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    o = obs4(); total++;
    if (o !== 4'b0001) begin bad++; $display("FAIL rmid_grant_rst: got=%b want=%b", o, 4'b0001); end
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_restart_idle: got=%b want=0", bus.busy); end
    $display("reset_mid: SETTLE and GRANT1 resets checked");
  endtask

  task automatic test_proto_idle();
    bus.lane0_done = 1'b1;
    @(negedge clk);
    bus.lane0_done = 1'b0;
    total++;
    if ({bus.proto_err, bus.busy, bus.lane0_grant} !== 3'b100) begin
      bad++; $display("FAIL perr_idle: got=%b want=100", {bus.proto_err, bus.busy, bus.lane0_grant});
    end
    $display("proto_idle: done in IDLE flagged");
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.lane0_req  = 1'b0;
    bus.lane1_req  = 1'b0;
    bus.lane0_done = 1'b0;
    bus.lane1_done = 1'b0;
    bus.active     = 1'b0;
    bus.fault      = 1'b0;
    @(negedge clk);
    test_reset();
    test_same_lane();
    test_cross_lane();
    test_fairness();
    test_proto_err();
    test_fault_sat();
    test_reset_mid();
    test_proto_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
